// File: rtl/add100_chunk_ctrl.sv
// Purpose : chunked operand loader / result drainer around the external 100-bit adder.
// Latency : last input beat at edge t -> EVAL in cycle t..t+1 -> first out_valid after edge t+1.
// Backpr. : out_ready=0 holds out_sum/out_last/out_cout; in_ready=0 outside LOAD (input ignored).
//
// Ports:
//   clk, resetn           single clock, async active-low reset
//   in_valid/in_ready     input beat handshake; in_a/in_b chunk (LSB chunk first), in_cin on beat 0
//   add_a/add_b/add_cin   operand registers driven to the adder at all times
//   add_sum/add_cout      adder result and per-bit carry vector, captured in EVAL
//   out_valid/out_ready   output beat handshake; out_sum chunk, out_cout final carry, out_last on MSB beat
//   out_ovf               signed overflow, present only when ADD100_OVF_EN is defined
module add100_chunk_ctrl #(
    parameter int CHUNK_W = 25
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] in_a,
    input  logic [CHUNK_W-1:0] in_b,
    input  logic               in_cin,
    output logic [99:0]        add_a,
    output logic [99:0]        add_b,
    output logic               add_cin,
    input  logic [99:0]        add_sum,
    input  logic [99:0]        add_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHUNK_W-1:0] out_sum,
    output logic               out_cout,
`ifdef ADD100_OVF_EN
    output logic               out_ovf,
`endif
    output logic               out_last
);

    localparam int NCHUNK = 100 / CHUNK_W;
    localparam int CNT_W  = $clog2(NCHUNK);

    generate
        if (!(CHUNK_W == 10 || CHUNK_W == 20 || CHUNK_W == 25 || CHUNK_W == 50)) begin : g_bad_chunk_w
            $error("add100_chunk_ctrl: CHUNK_W must be one of 10, 20, 25, 50");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [99:0]        a_q, a_d;
    logic [99:0]        b_q, b_d;
    logic               cin_q, cin_d;
    logic [99:0]        res_q, res_d;
    logic               cout_q, cout_d;
    logic               cnt_last;
`ifdef ADD100_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    // Only the top carries are consumed; the rest of the vector is intentionally unused.
    logic unused_cout;
    assign unused_cout = ^add_cout[97:0];

    assign cnt_last = (cnt_q == CNT_W'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        res_d   = res_q;
        cout_d  = cout_q;
`ifdef ADD100_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    a_d[int'(cnt_q)*CHUNK_W +: CHUNK_W] = in_a;
                    b_d[int'(cnt_q)*CHUNK_W +: CHUNK_W] = in_b;
                    if (cnt_q == '0) begin
                        cin_d = in_cin;
                    end
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ST_EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_EVAL: begin
                // Operands have been stable for this whole cycle, so the ripple has settled.
                res_d   = add_sum;
                cout_d  = add_cout[99];
`ifdef ADD100_OVF_EN
                ovf_d   = add_cout[99] ^ add_cout[98];
`endif
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADD100_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
`ifdef ADD100_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_DRAIN);
    // Result chunk is gated so stale results never appear outside DRAIN.
    assign out_sum   = out_valid ? res_q[int'(cnt_q)*CHUNK_W +: CHUNK_W] : '0;
    assign out_last  = out_valid && cnt_last;
    assign out_cout  = cout_q;
`ifdef ADD100_OVF_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add100_chunk_ctrl.sv
// Purpose : self-checking bench for add100_chunk_ctrl with an emulated ripple adder.
// Latency : expected results come from plain 101-bit arithmetic on the whole operands.
// Backpr. : directed stalls plus randomized out_ready and input gaps.
module tb_add100_chunk_ctrl;

    localparam int W = 25;
    localparam int N = 100 / W;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic [99:0]   add_a;
    logic [99:0]   add_b;
    logic          add_cin;
    logic [99:0]   add_sum;
    logic [99:0]   add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_last;
`ifdef ADD100_OVF_EN
    logic          out_ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    add100_chunk_ctrl #(.CHUNK_W(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
`ifdef ADD100_OVF_EN
        .out_ovf   (out_ovf),
`endif
        .out_last  (out_last)
    );

    // Stand-in for the external combinational ripple-carry adder.
    always_comb begin
        logic c;
        c        = add_cin;
        add_sum  = '0;
        add_cout = '0;
        for (int i = 0; i < 100; i++) begin
            add_sum[i]  = add_a[i] ^ add_b[i] ^ c;
            c           = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
            add_cout[i] = c;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),  128'd1);
        chk({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        chk({tag, "_out_last"},  128'(out_last),  128'd0);
        chk({tag, "_out_sum"},   128'(out_sum),   128'd0);
    endtask

    // One complete transaction: load, EVAL checks, drain with optional stall / random backpressure.
    task automatic run_txn(input logic [99:0] a, input logic [99:0] b, input logic cin,
                           input int stall_beat, input int stall_len, input bit rnd);
        logic [100:0] full;
        logic         exp_ovf;
        int           k;
        int           cyc;
        int           stalled;
        logic         rdy;
        full    = {1'b0, a} + {1'b0, b} + 101'(cin);
        exp_ovf = (a[99] == b[99]) && (full[99] != a[99]);
        for (int j = 0; j < N; j++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    in_a     = W'($urandom);
                    @(negedge clk);
                end
            end
            chk("load_in_ready", 128'(in_ready), 128'd1);
            in_valid = 1'b1;
            in_a     = a[j*W +: W];
            in_b     = b[j*W +: W];
            in_cin   = (j == 0) ? cin : ~cin;
            @(negedge clk);
        end
        // EVAL cycle: junk offered on the input must be ignored.
        in_valid = 1'b1;
        in_a     = W'($urandom);
        in_b     = W'($urandom);
        in_cin   = ~cin;
        chk("eval_in_ready",  128'(in_ready),  128'd0);
        chk("eval_out_valid", 128'(out_valid), 128'd0);
        chk("eval_add_a",     128'(add_a),     128'(a));
        chk("eval_add_b",     128'(add_b),     128'(b));
        chk("eval_add_cin",   128'(add_cin),   128'(cin));
        @(negedge clk);
        k       = 0;
        cyc     = 0;
        stalled = 0;
        while (k < N && cyc < 200) begin
            chk("drain_out_valid", 128'(out_valid), 128'd1);
            chk("drain_in_ready",  128'(in_ready),  128'd0);
            chk("drain_out_sum",   128'(out_sum),   128'(full[k*W +: W]));
            chk("drain_out_last",  128'(out_last),  128'(k == N - 1));
            chk("drain_out_cout",  128'(out_cout),  128'(full[100]));
`ifdef ADD100_OVF_EN
            chk("drain_out_ovf",   128'(out_ovf),   128'(exp_ovf));
`endif
            if (k == stall_beat && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else begin
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            out_ready = rdy;
            in_a      = W'($urandom);
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        chk("drain_beats", 128'(k), 128'(N));
        if (!rnd) chk("drain_cycles", 128'(cyc), 128'(N + stall_len));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_idle("post_drain");
    endtask

    initial begin
        logic [127:0] ra;
        logic [127:0] rb;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_out_cout", 128'(out_cout), 128'd0);
        chk("reset_add_a",    128'(add_a),    128'd0);
        chk("reset_add_b",    128'(add_b),    128'd0);
        chk("reset_add_cin",  128'(add_cin),  128'd0);
`ifdef ADD100_OVF_EN
        chk("reset_out_ovf",  128'(out_ovf),  128'd0);
`endif
        resetn = 1'b1;
        @(negedge clk);
        chk_idle("after_release");

        // Carry ripples across every chunk boundary.
        run_txn({100{1'b1}}, 100'd1, 1'b0, -1, 0, 1'b0);

        // Reset while idle.
        resetn = 1'b0;
        #1;
        chk_idle("idle_reset");
        chk("idle_reset_out_cout", 128'(out_cout), 128'd0);
        chk("idle_reset_add_a",    128'(add_a),    128'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Carry-in only.
        run_txn(100'd0, 100'd0, 1'b1, -1, 0, 1'b0);

        // Alternating pattern with a 5-cycle stall on beat 2.
        run_txn({25{4'h5}}, {25{4'hA}}, 1'b0, 2, 5, 1'b0);

        // Abort a partial load with reset, then run a clean transaction.
        for (int j = 0; j < 2; j++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_cin   = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        resetn   = 1'b0;
        #1;
        chk("abort_add_a",   128'(add_a),   128'd0);
        chk("abort_add_b",   128'(add_b),   128'd0);
        chk("abort_add_cin", 128'(add_cin), 128'd0);
        chk_idle("abort");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_txn(100'd3, 100'd4, 1'b0, -1, 0, 1'b0);

        // Signed overflow into the MSB.
        run_txn({1'b0, {99{1'b1}}}, 100'd1, 1'b0, -1, 0, 1'b0);

        // Randomized transactions with input gaps and random backpressure.
        for (int t = 0; t < 20; t++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (t % 4 == 0) rb = ~ra;
            run_txn(ra[99:0], rb[99:0], 1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                    int'($urandom_range(0, 3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/add100_chunk_ctrl.md
# add100_chunk_ctrl

Operand loader and result drainer for the 100-bit ripple-carry adder (`adder100i_module`). It assembles two 100-bit operands from a narrow chunked input stream and presents them, with a carry-in, to the adder. It then captures the adder's sum and carry vector and streams the result back out in chunks. It sits between a narrow datapath bus and the combinational adder, and owns all sequencing around it.

## Interface
- `CHUNK_W`, default 25: chunk width in bits.
  - Legal values: 10, 20, 25, 50 (must divide 100).
  - `NCHUNK = 100/CHUNK_W`.
  - An illegal value fails elaboration.
- `clk` input 1: single clock, rising edge.
- `resetn` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block accepts input beat.
- `in_a` input CHUNK_W: operand A chunk, LSB chunk first.
- `in_b` input CHUNK_W: operand B chunk, LSB chunk first.
- `in_cin` input 1: carry-in, sampled on beat 0 only.
- `add_a` output 100: operand A to adder.
- `add_b` output 100: operand B to adder.
- `add_cin` output 1: carry-in to adder.
- `add_sum` input 100: adder sum.
- `add_cout` input 100: adder per-bit carry-out vector.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: consumer accepts output beat.
- `out_sum` output CHUNK_W: result chunk, LSB chunk first.
- `out_cout` output 1: final carry (`add_cout[99]`), held on every drain beat.
- `out_last` output 1: high on the final (MSB) output beat.

## Operation
- **State machine:** LOAD, EVAL, DRAIN. Reset enters LOAD.
- **LOAD**
  - `in_ready=1`.
  - Each `in_valid&&in_ready` cycle writes `in_a`/`in_b` into slice `[k*CHUNK_W +: CHUNK_W]` of the A/B registers, where k is the beat counter (0..NCHUNK-1).
  - On beat 0, `in_cin` is captured into the cin register.
  - After beat NCHUNK-1 the counter clears and the state moves to EVAL.
- **Adder drive:** `add_a`, `add_b` and `add_cin` are driven directly from the operand registers at all times. Partially loaded values are visible during LOAD.
- **EVAL** (exactly one cycle)
  - `in_ready=0`, `out_valid=0`.
  - Registers `add_sum` into the result register and `add_cout[99]` into the cout register.
  - Moves to DRAIN.
- **DRAIN**
  - `out_valid=1`, `out_sum` = result slice k, `out_last=(k==NCHUNK-1)`.
  - The counter advances only on `out_valid&&out_ready`.
  - On the last accepted beat the counter clears and the state returns to LOAD.
- **Backpressure:** while `out_ready=0`, `out_sum`, `out_last` and `out_cout` hold stable.
- **Input outside LOAD:** `in_valid` asserted outside LOAD is ignored (`in_ready=0`). No data is lost or duplicated.
- **Input gaps:** gaps in `in_valid` are allowed; the counter does not advance.
- **No overlap:** a new load never starts before DRAIN completes.
- **Arithmetic:** performed entirely by the external adder. The block does no arithmetic beyond counter increment. Counter width is `$clog2(NCHUNK)`.

## Timing
- **Reset values:**
  - `in_ready=1`, `out_valid=0`, `out_last=0`, `out_sum=0`, `out_cout=0`.
  - `add_a=0`, `add_b=0`, `add_cin=0`.
  - Counter is 0 and state is LOAD.
- **Reset mid-operation** (any state): the partial transaction is discarded immediately and all registers return to reset values.
- **Latency:**
  - If the last input beat is accepted at edge t, EVAL occupies cycle t..t+1.
  - The first `out_valid` is seen after edge t+1.
  - With `out_ready` tied high, DRAIN lasts NCHUNK cycles.
- **Minimum transaction period:** 2·NCHUNK+1 cycles.
- **Combinational path:** the adder path from register to register is one full cycle (ripple through 100 bits).
- **`in_ready` deassertion:** `in_ready` falls in the cycle after the last input beat. It is registered-state-derived, not combinational on `in_valid`.

## Configuration
- **`ADD100_OVF_EN` defined:**
  - Adds output `out_ovf` (1 bit), signed two's-complement overflow = `add_cout[99]^add_cout[98]`.
  - Captured in EVAL and held through DRAIN.
  - Reset value 0.
- **`ADD100_OVF_EN` undefined:** the port and its register are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `resetn=0` mid-idle, release.
  - Required: `in_ready=1`, `out_valid=0`, all outputs 0.
- **Carry ripple:** CHUNK_W=25, A=all ones, B=1, cin=0.
  - Required: 4 out beats, each `out_sum=0`, `out_cout=1`, `out_last` on beat 3 only.
- **Carry-in only:** A=0, B=0, cin=1.
  - Required: beat0 `out_sum=1`, beats1–3 =0, `out_cout=0`.
- **Backpressure:** A=`0x5…5`, B=`0xA…A`, cin=0; hold `out_ready=0` for 5 cycles at beat 2.
  - Required: `out_sum=0x1FFFFFF` stable throughout, no beat skipped, `out_cout=0`.
- **Reset abort:** assert `resetn` low after 2 input beats, then send a full transaction A=3, B=4.
  - Required: result beat0=7, others 0; no residue from the aborted load.
- **Overflow (with `ADD100_OVF_EN`):** A=2^99−1, B=1, cin=0.
  - Required: beat3 `out_sum` MSB set, `out_ovf=1`, `out_cout=0`.
